// File: rtl/exec_pkg.sv
// exec_pkg: shared ALU opcodes, mul/div FSM states and default widths for the EX stage
package exec_pkg;
    localparam int EX_DATA_W = 32;
    localparam int EX_REG_W  = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MUL  = 4'b1001;
    localparam logic [3:0] ALU_DIVU = 4'b1010;
    localparam logic [3:0] ALU_REMU = 4'b1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op == ALU_MUL || op == ALU_DIVU || op == ALU_REMU;
    endfunction
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative unsigned shift-add multiply and restoring divide, one bit per cycle
module iter_muldiv
    import exec_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int ITER   = EX_DATA_W
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result
);
    localparam int CW = $clog2(ITER);

    md_state_t         r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_op;
    // r_x: product accumulator / partial remainder
    // r_y: shifting multiplicand / dividend shifting into quotient
    // r_z: shifting multiplier / fixed divisor
    logic [DATA_W-1:0] r_x, r_y, r_z;
    logic [DATA_W:0]   w_rem_sh, w_diff;
    logic              w_last;

    assign w_last   = r_cnt == CW'(ITER - 1);
    assign w_rem_sh = {r_x, r_y[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_z};
    assign o_busy   = r_state == BUSY;
    assign o_done   = r_state == DONE;
    assign o_result = r_op == ALU_DIVU ? r_y : r_x;

    // Next-state: issue -> ITER step cycles -> one DONE cycle -> back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? BUSY : IDLE;
            BUSY:    w_next = w_last ? DONE : BUSY;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    // Latch operands on issue, then one multiply or divide step per BUSY cycle
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_cnt <= '0;
            r_op  <= i_op;
            r_x   <= '0;
            r_y   <= i_a;
            r_z   <= i_b;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_op == ALU_MUL) begin
                r_x <= r_z[0] ? r_x + r_y : r_x;
                r_y <= r_y << 1;
                r_z <= r_z >> 1;
            end else begin
                // A zero divisor never goes negative, giving all-ones quotient and remainder = dividend
                r_x <= w_diff[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
                r_y <= {r_y[DATA_W-2:0], ~w_diff[DATA_W]};
            end
        end
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage ALU, mul/div stall control, branch adder and EX/MEM register
module execute_stage
    import exec_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int REG_W  = EX_REG_W,
    parameter int ITER   = EX_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [REG_W-1:0]  reg_dest_in,
    input  logic              MemWrite_in,
    input  logic              Branch_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    output logic              stall,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero_signal,
    output logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] branch_target,
    output logic [REG_W-1:0]  reg_dest,
    output logic              MemWrite,
    output logic              Branch,
    output logic              RegWrite,
    output logic              MemtoReg
);
    logic              w_busy, w_done, w_issue, w_bubble;
    logic [DATA_W-1:0] w_md_result, w_alu, w_result;

    iter_muldiv #(.DATA_W(DATA_W), .ITER(ITER)) u_md (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_start   (w_issue),
        .i_op      (alu_ctrl),
        .i_a       (operand_a),
        .i_b       (operand_b),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_result  (w_md_result)
    );

    // Issue only from IDLE; DONE lets the held instruction retire before any new mul/div issues
    assign w_issue  = valid_in && is_muldiv(alu_ctrl) && !w_busy && !w_done;
    assign stall    = w_issue || w_busy;
    assign w_bubble = stall || !valid_in;
    assign w_result = w_done ? w_md_result : w_alu;

    // Single-cycle ALU; mul/div codes and undefined codes give 0 here
    always_comb begin
        w_alu = '0;
        case (alu_ctrl)
            ALU_AND: w_alu = operand_a & operand_b;
            ALU_OR:  w_alu = operand_a | operand_b;
            ALU_ADD: w_alu = operand_a + operand_b;
            ALU_SUB: w_alu = operand_a - operand_b;
            ALU_SLT: w_alu = {{(DATA_W-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            ALU_NOR: w_alu = ~(operand_a | operand_b);
            default: w_alu = '0;
        endcase
    end

    // EX/MEM register: bubbles clear controls, destination and data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_result    <= '0;
            zero_signal   <= 1'b0;
            in_data       <= '0;
            branch_target <= '0;
            reg_dest      <= '0;
            MemWrite      <= 1'b0;
            Branch        <= 1'b0;
            RegWrite      <= 1'b0;
            MemtoReg      <= 1'b0;
        end else begin
            alu_result    <= w_bubble ? '0 : w_result;
            zero_signal   <= w_bubble || w_result == '0;
            in_data       <= w_bubble ? '0 : store_data;
            branch_target <= w_bubble ? '0 : pc_plus4 + (imm_ext << 2);
            reg_dest      <= w_bubble ? '0 : reg_dest_in;
            MemWrite      <= !w_bubble && MemWrite_in;
            Branch        <= !w_bubble && Branch_in;
            RegWrite      <= !w_bubble && RegWrite_in;
            MemtoReg      <= !w_bubble && MemtoReg_in;
        end
    end
endmodule
